rs232_cmd_decoder: RTL
======================

# rs232_cmd_decoder

Parametrised, fully synchronous command decoder for the PC-to-FPGA serial link of the waveform generator. It consumes a validated byte stream from the UART receiver, parses the command protocol and emits single-cycle strobes carrying channel, time, period and value data to the waveform memory and channel controllers. Compared with the previous decoder it adds:
- configurable channel count, time width and value width;
- per-channel last-time marking;
- an inactivity timeout;
- error reporting.

## Interface
Parameters:
- TIME_W, 32, width of time/period words; must be a multiple of 8; TB = TIME_W/8 bytes, MSB first.
- VAL_W, 1, channel value width (1..8), taken from the low bits of the value byte.
- NUM_CH, 64, number of valid channels (1..255); byte 0xFF is the reserved terminator.
- TIMEOUT, 500000, idle iCLK cycles tolerated mid-command before abort.
- C_WAVE/C_PERIOD/C_INIT/C_VAL, 8'h01/8'h02/8'h03/8'h04, data command codes.
- C_ARM/C_TOINIT/C_RSTTIME/C_RSTDEV, 8'h10/8'h11/8'h12/8'h13, single-byte command codes.

Ports:
- iCLK  in  1  system clock.
- iNRST  in  1  asynchronous, active-low reset.
- iRX_VALID  in  1  one-cycle strobe: iRX_DATA holds a received byte.
- iRX_DATA  in  8  received byte.
- oBUSY  out  1  high while not in IDLE.
- oTIME_VALID  out  1  one-cycle strobe: oCHANNEL/oTIME/oLAST valid (waveform entry).
- oLAST  out  1  entry is the final (or empty) entry of its channel.
- oPERIOD_VALID  out  1  one-cycle strobe: oTIME holds the new period.
- oINIT_VALID  out  1  one-cycle strobe: oCHANNEL/oVALUE hold an initial value.
- oFORCE_VALID  out  1  one-cycle strobe: oCHANNEL/oVALUE hold a forced value.
- oCHANNEL  out  8  channel index.
- oTIME  out  TIME_W  time or period word.
- oVALUE  out  VAL_W  channel value.
- oARM, oTO_INIT, oRESET_TIME, oRESET_DEV  out  1 each  one-cycle command strobes.
- oERR  out  1  one-cycle error strobe.
- oERR_CODE  out  2  1 = timeout, 2 = channel out of range, 3 = unknown command; held until the next error.

## Operation
- States:
  - IDLE.
  - W_CH, W_CNT0, W_CNT1, W_TIME (byte index 0..TB-1).
  - P_TIME.
  - V_CH, V_VAL (shared by init and force).
- IDLE: a byte equal to a data command code enters its first state; W_CH for C_WAVE, V_CH for C_INIT/C_VAL, P_TIME for C_PERIOD.
- IDLE: a single-byte command code pulses its strobe and stays in IDLE.
- IDLE: any other byte pulses oERR with code 3 and stays in IDLE.
- W_CH: 0xFF → IDLE. Channel < NUM_CH → latch it, go to W_CNT0. Otherwise → oERR code 2, go to IDLE.
- W_CNT0/W_CNT1: 16-bit remaining count, MSB first.
  - Count 0 → one oTIME_VALID with oTIME=0 and oLAST=1, then W_CH.
  - Otherwise → W_TIME.
- W_TIME: shift bytes into the time word. After byte TB-1: pulse oTIME_VALID and decrement the count. oLAST=1 when the count reaches 0, then go to W_CH; otherwise stay in W_TIME with index 0.
- P_TIME: after TB bytes, pulse oPERIOD_VALID and go to IDLE.
- V_CH: 0xFF → IDLE. Valid channel → V_VAL. Out of range → oERR code 2, go to IDLE.
- V_VAL: pulse oINIT_VALID or oFORCE_VALID with oVALUE = byte[VAL_W-1:0], then return to V_CH.
- Timeout:
  - The idle counter clears on every iRX_VALID and while in IDLE.
  - When it reaches TIMEOUT in any other state: oERR code 1, go to IDLE, discard the partial word.
  - If iRX_VALID arrives in the same cycle the count hits TIMEOUT, the byte wins and there is no timeout.
- The time shift register clears on entry to W_TIME/P_TIME, so stale bytes never leak into a word.

## Timing
- All outputs are registered. A strobe asserts the cycle after the iRX_VALID cycle of its completing byte and lasts exactly 1 cycle.
- oCHANNEL/oTIME/oVALUE/oLAST remain stable until the next strobe.
- Back-to-back iRX_VALID on consecutive cycles is supported at full rate with no byte loss.
- Reset:
  - State IDLE; all strobes 0; oBUSY=0; oLAST=0.
  - oCHANNEL=8'hFF; oTIME=0; oVALUE=0; oERR_CODE=0; counters 0.
  - Reset asserted mid-command aborts it with no strobe.
- oBUSY is low in the cycle after the transition to IDLE.

## Test plan
- Wave: 01 05 00 02 00 00 00 0A 00 00 01 00 FF → two oTIME_VALID pulses: ch5 time 0x0A with oLAST=0, then ch5 time 0x100 with oLAST=1; then oBUSY=0.
- Empty channel: 01 07 00 00 FF → one oTIME_VALID with ch7, oTIME=0, oLAST=1.
- Period and commands: 02 00 0F 42 40 → oPERIOD_VALID with oTIME=1000000. Then 10 13 → oARM followed by oRESET_DEV, one cycle apart in the output sequence.
- Init/force with VAL_W=4: 03 02 0B FF → oINIT_VALID ch2 value 0xB. Then 04 03 01 FF → oFORCE_VALID ch3 value 1.
- Errors with NUM_CH=64: 01 40 → oERR code 2, IDLE. Byte 55 in IDLE → oERR code 3. 02 00 00 then silence for TIMEOUT cycles → oERR code 1 and no oPERIOD_VALID.
- Reset mid-stream: iNRST low after 01 05 00 → all outputs return to reset values; a following 10 yields oARM.

Source files
------------

// File: rtl/rs232_cmd_decoder_if.sv
// Byte-stream input and decoded-strobe outputs of the serial command decoder.
// Latency: none, wires only. Backpressure: none; the decoder always accepts.
interface rs232_cmd_decoder_if #(
    parameter int TIME_W = 32,
    parameter int VAL_W  = 1
);
    logic              iRX_VALID;
    logic [7:0]        iRX_DATA;
    logic              oBUSY;
    logic              oTIME_VALID;
    logic              oLAST;
    logic              oPERIOD_VALID;
    logic              oINIT_VALID;
    logic              oFORCE_VALID;
    logic [7:0]        oCHANNEL;
    logic [TIME_W-1:0] oTIME;
    logic [VAL_W-1:0]  oVALUE;
    logic              oARM;
    logic              oTO_INIT;
    logic              oRESET_TIME;
    logic              oRESET_DEV;
    logic              oERR;
    logic [1:0]        oERR_CODE;

    modport master (
        output iRX_VALID, iRX_DATA,
        input  oBUSY, oTIME_VALID, oLAST, oPERIOD_VALID, oINIT_VALID, oFORCE_VALID,
               oCHANNEL, oTIME, oVALUE, oARM, oTO_INIT, oRESET_TIME, oRESET_DEV,
               oERR, oERR_CODE
    );

    modport slave (
        input  iRX_VALID, iRX_DATA,
        output oBUSY, oTIME_VALID, oLAST, oPERIOD_VALID, oINIT_VALID, oFORCE_VALID,
               oCHANNEL, oTIME, oVALUE, oARM, oTO_INIT, oRESET_TIME, oRESET_DEV,
               oERR, oERR_CODE
    );
endinterface

// File: rtl/rs232_cmd_decoder.sv
// Parses the PC command byte stream into waveform/period/value/command strobes.
// Latency: strobes 1 cycle after the completing byte. Backpressure: none, full-rate input.
module rs232_cmd_decoder #(
    parameter int         TIME_W    = 32,
    parameter int         VAL_W     = 1,
    parameter int         NUM_CH    = 64,
    parameter int         TIMEOUT   = 500000,
    parameter logic [7:0] C_WAVE    = 8'h01,
    parameter logic [7:0] C_PERIOD  = 8'h02,
    parameter logic [7:0] C_INIT    = 8'h03,
    parameter logic [7:0] C_VAL     = 8'h04,
    parameter logic [7:0] C_ARM     = 8'h10,
    parameter logic [7:0] C_TOINIT  = 8'h11,
    parameter logic [7:0] C_RSTTIME = 8'h12,
    parameter logic [7:0] C_RSTDEV  = 8'h13
) (
    input logic                 iCLK,
    input logic                 iNRST,
    rs232_cmd_decoder_if.slave  bus
);
    localparam int TB    = TIME_W / 8;
    localparam int IDX_W = (TB > 1) ? $clog2(TB) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [2:0] {
        IDLE, W_CH, W_CNT0, W_CNT1, W_TIME, P_TIME, V_CH, V_VAL
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [TIME_W-1:0] sh_q, sh_d;
    logic [7:0]        ch_q, ch_d;
    logic              force_q, force_d;
    logic [CNT_W-1:0]  tmo_q, tmo_d;

    logic              busy_q, busy_d;
    logic              time_vld_q, time_vld_d;
    logic              last_q, last_d;
    logic              period_vld_q, period_vld_d;
    logic              init_vld_q, init_vld_d;
    logic              force_vld_q, force_vld_d;
    logic [7:0]        chan_q, chan_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic [VAL_W-1:0]  value_q, value_d;
    logic              arm_q, arm_d;
    logic              toinit_q, toinit_d;
    logic              rsttime_q, rsttime_d;
    logic              rstdev_q, rstdev_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;

    logic              rx;
    logic [7:0]        b;
    logic [TIME_W-1:0] sh_next;
    logic              ch_ok;
    logic [15:0]       cnt_full;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        ch_d         = ch_q;
        force_d      = force_q;
        time_vld_d   = 1'b0;
        period_vld_d = 1'b0;
        init_vld_d   = 1'b0;
        force_vld_d  = 1'b0;
        arm_d        = 1'b0;
        toinit_d     = 1'b0;
        rsttime_d    = 1'b0;
        rstdev_d     = 1'b0;
        err_d        = 1'b0;
        last_d       = last_q;
        chan_d       = chan_q;
        time_d       = time_q;
        value_d      = value_q;
        err_code_d   = err_code_q;

        rx       = bus.iRX_VALID;
        b        = bus.iRX_DATA;
        sh_next  = TIME_W'({sh_q, b});
        ch_ok    = (32'(b) < NUM_CH);
        cnt_full = {cnt_q[15:8], b};

        // A byte arriving in the cycle the count hits TIMEOUT clears it before it can fire.
        if (state_q == IDLE || rx)
            tmo_d = '0;
        else if (tmo_q == CNT_W'(TIMEOUT))
            tmo_d = tmo_q;
        else
            tmo_d = tmo_q + CNT_W'(1);

        if (state_q != IDLE && !rx && tmo_q == CNT_W'(TIMEOUT)) begin
            state_d    = IDLE;
            sh_d       = '0;
            idx_d      = '0;
            err_d      = 1'b1;
            err_code_d = 2'd1;
        end else if (rx) begin
            case (state_q)
                IDLE: begin
                    if (b == C_WAVE) begin
                        state_d = W_CH;
                    end else if (b == C_PERIOD) begin
                        state_d = P_TIME;
                        sh_d    = '0;
                        idx_d   = '0;
                    end else if (b == C_INIT || b == C_VAL) begin
                        state_d = V_CH;
                        force_d = (b == C_VAL);
                    end else if (b == C_ARM) begin
                        arm_d = 1'b1;
                    end else if (b == C_TOINIT) begin
                        toinit_d = 1'b1;
                    end else if (b == C_RSTTIME) begin
                        rsttime_d = 1'b1;
                    end else if (b == C_RSTDEV) begin
                        rstdev_d = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'd3;
                    end
                end
                W_CH, V_CH: begin
                    if (b == 8'hFF) begin
                        state_d = IDLE;
                    end else if (ch_ok) begin
                        ch_d    = b;
                        state_d = (state_q == W_CH) ? W_CNT0 : V_VAL;
                    end else begin
                        state_d    = IDLE;
                        err_d      = 1'b1;
                        err_code_d = 2'd2;
                    end
                end
                W_CNT0: begin
                    cnt_d   = {b, 8'h00};
                    state_d = W_CNT1;
                end
                W_CNT1: begin
                    if (cnt_full == 16'd0) begin
                        time_vld_d = 1'b1;
                        chan_d     = ch_q;
                        time_d     = '0;
                        last_d     = 1'b1;
                        state_d    = W_CH;
                    end else begin
                        cnt_d   = cnt_full;
                        sh_d    = '0;
                        idx_d   = '0;
                        state_d = W_TIME;
                    end
                end
                W_TIME, P_TIME: begin
                    if (idx_q == IDX_W'(TB - 1)) begin
                        sh_d   = '0;
                        idx_d  = '0;
                        time_d = sh_next;
                        if (state_q == P_TIME) begin
                            period_vld_d = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            time_vld_d = 1'b1;
                            chan_d     = ch_q;
                            cnt_d      = cnt_q - 16'd1;
                            last_d     = (cnt_q == 16'd1);
                            if (cnt_q == 16'd1)
                                state_d = W_CH;
                        end
                    end else begin
                        sh_d  = sh_next;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                V_VAL: begin
                    init_vld_d  = !force_q;
                    force_vld_d = force_q;
                    chan_d      = ch_q;
                    value_d     = b[VAL_W-1:0];
                    state_d     = V_CH;
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge iCLK or negedge iNRST) begin
        if (!iNRST) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            sh_q         <= '0;
            ch_q         <= '0;
            force_q      <= 1'b0;
            tmo_q        <= '0;
            busy_q       <= 1'b0;
            time_vld_q   <= 1'b0;
            last_q       <= 1'b0;
            period_vld_q <= 1'b0;
            init_vld_q   <= 1'b0;
            force_vld_q  <= 1'b0;
            chan_q       <= 8'hFF;
            time_q       <= '0;
            value_q      <= '0;
            arm_q        <= 1'b0;
            toinit_q     <= 1'b0;
            rsttime_q    <= 1'b0;
            rstdev_q     <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= 2'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            ch_q         <= ch_d;
            force_q      <= force_d;
            tmo_q        <= tmo_d;
            busy_q       <= busy_d;
            time_vld_q   <= time_vld_d;
            last_q       <= last_d;
            period_vld_q <= period_vld_d;
            init_vld_q   <= init_vld_d;
            force_vld_q  <= force_vld_d;
            chan_q       <= chan_d;
            time_q       <= time_d;
            value_q      <= value_d;
            arm_q        <= arm_d;
            toinit_q     <= toinit_d;
            rsttime_q    <= rsttime_d;
            rstdev_q     <= rstdev_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign bus.oBUSY         = busy_q;
    assign bus.oTIME_VALID   = time_vld_q;
    assign bus.oLAST         = last_q;
    assign bus.oPERIOD_VALID = period_vld_q;
    assign bus.oINIT_VALID   = init_vld_q;
    assign bus.oFORCE_VALID  = force_vld_q;
    assign bus.oCHANNEL      = chan_q;
    assign bus.oTIME         = time_q;
    assign bus.oVALUE        = value_q;
    assign bus.oARM          = arm_q;
    assign bus.oTO_INIT      = toinit_q;
    assign bus.oRESET_TIME   = rsttime_q;
    assign bus.oRESET_DEV    = rstdev_q;
    assign bus.oERR          = err_q;
    assign bus.oERR_CODE     = err_code_q;
endmodule
